// File: rtl/periph_timer_bank.sv
// Memory-mapped bank of reload timers with LED, switch and digit ports on a 256-byte bus window.
// Optional PERIPH_SW_SYNC_EN: switch pins pass a 2-flop synchronizer before being read.
module periph_timer_bank #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          N_TIMERS  = 2,
   parameter int          CNT_W     = 32,
   parameter int          PRESC_W   = 16,
   parameter int          LED_W     = 8,
   parameter int          SW_W      = 8,
   parameter int          DIGI_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [LED_W-1:0]  led,
   input  logic [SW_W-1:0]   switch,
   output logic [DIGI_W-1:0] digi,
   output logic              irqout
);

   typedef struct packed {
      logic [CNT_W-1:0]   th;
      logic [CNT_W-1:0]   tl;
      logic [PRESC_W-1:0] presc;
      logic [PRESC_W-1:0] pcnt;
      logic               one_shot;
      logic               irq_en;
      logic               en;
   } tmr_t;

   typedef enum logic [1:0] {
      R_TH    = 2'd0,
      R_TL    = 2'd1,
      R_TCON  = 2'd2,
      R_PRESC = 2'd3
   } tmr_reg_e;

   localparam logic [5:0] W_LED    = 6'h00;
   localparam logic [5:0] W_SWITCH = 6'h01;
   localparam logic [5:0] W_DIGI   = 6'h02;
   localparam logic [5:0] W_STAT   = 6'h03;
   localparam logic [5:0] W_MASK   = 6'h04;

   logic [LED_W-1:0]    led_q, led_d;
   logic [DIGI_W-1:0]   digi_q, digi_d;
   logic [N_TIMERS-1:0] irq_stat_q, irq_stat_d;
   logic [N_TIMERS-1:0] irq_mask_q, irq_mask_d;
   logic                irqout_q, irqout_d;
   tmr_t                tmr_q [N_TIMERS];
   tmr_t                tmr_d [N_TIMERS];

   logic                in_win;
   logic                bus_wr;
   logic [5:0]          word;
   tmr_reg_e            tsel;
   logic [N_TIMERS-1:0] ch_hit;
   logic [N_TIMERS-1:0] tick;
   logic [N_TIMERS-1:0] ovf;
   logic [N_TIMERS-1:0] irq_set;
   logic [N_TIMERS-1:0] irq_clr;
   logic [SW_W-1:0]     sw_val;

   // Misaligned addresses are treated as outside the window.
   assign in_win = (addr[31:8] == BASE_ADDR[31:8]) && (addr[1:0] == 2'b00);
   assign bus_wr = wr && in_win;
   assign word   = addr[7:2];
   assign tsel   = tmr_reg_e'(word[1:0]);

   // Channel i occupies the 16-byte block at 0x20 + 0x10*i.
   always_comb begin
      ch_hit = '0;
      for (int i = 0; i < N_TIMERS; i++) begin
         ch_hit[i] = in_win && (word[5:2] == 4'(i + 2));
      end
   end

`ifdef PERIPH_SW_SYNC_EN
   logic [SW_W-1:0] sw_meta_q, sw_meta_d;
   logic [SW_W-1:0] sw_sync_q, sw_sync_d;

   always_comb begin
      sw_meta_d = switch;
      sw_sync_d = sw_meta_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   assign sw_val = sw_sync_q;
`else
   assign sw_val = switch;
`endif

   always_comb begin
      tick = '0;
      ovf  = '0;
      for (int i = 0; i < N_TIMERS; i++) begin
         tick[i] = tmr_q[i].en && (tmr_q[i].pcnt == tmr_q[i].presc);
         ovf[i]  = tick[i] && (tmr_q[i].tl == '1);
      end
   end

   // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      led_d      = led_q;
      digi_d     = digi_q;
      irq_mask_d = irq_mask_q;
      irq_set    = '0;

      for (int i = 0; i < N_TIMERS; i++) begin
         // NOTE: blocking assignments here let a bus write further down override the counter update computed above it.
         tmr_d[i] = tmr_q[i];

         if (!tmr_q[i].en || tick[i]) begin
            tmr_d[i].pcnt = '0;
         end else begin
            tmr_d[i].pcnt = tmr_q[i].pcnt + PRESC_W'(1);
         end

         if (tick[i]) begin
            tmr_d[i].tl = ovf[i] ? tmr_q[i].th : tmr_q[i].tl + CNT_W'(1);
         end

         if (ovf[i]) begin
            irq_set[i] = tmr_q[i].irq_en;
            if (tmr_q[i].one_shot) begin
               tmr_d[i].en = 1'b0;
            end
         end

         if (bus_wr && ch_hit[i]) begin
            case (tsel)
               R_TH:    tmr_d[i].th = wdata[CNT_W-1:0];
               R_TL:    tmr_d[i].tl = wdata[CNT_W-1:0];
               R_TCON: begin
                  tmr_d[i].en       = wdata[0];
                  tmr_d[i].irq_en   = wdata[1];
                  tmr_d[i].one_shot = wdata[2];
                  // Only a running channel that stays enabled keeps its prescale phase.
                  if (!(wdata[0] && tmr_q[i].en)) begin
                     tmr_d[i].pcnt = '0;
                  end
               end
               R_PRESC: begin
                  tmr_d[i].presc = wdata[PRESC_W-1:0];
                  tmr_d[i].pcnt  = '0;
               end
            endcase
         end
      end

      if (bus_wr && (word == W_LED)) begin
         led_d = wdata[LED_W-1:0];
      end
      if (bus_wr && (word == W_DIGI)) begin
         digi_d = wdata[DIGI_W-1:0];
      end
      if (bus_wr && (word == W_MASK)) begin
         irq_mask_d = wdata[N_TIMERS-1:0];
      end

      // A set from an overflow on the same edge beats the write-1-to-clear.
      irq_clr    = (bus_wr && (word == W_STAT)) ? wdata[N_TIMERS-1:0] : '0;
      irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
      irqout_d   = |(irq_stat_d & irq_mask_d);
   end

   always_comb begin
      rdata = '0;
      if (rd && in_win) begin
         case (word)
            W_LED:    rdata = 32'(led_q);
            W_SWITCH: rdata = 32'(sw_val);
            W_DIGI:   rdata = 32'(digi_q);
            W_STAT:   rdata = 32'(irq_stat_q);
            W_MASK:   rdata = 32'(irq_mask_q);
            default:  rdata = '0;
         endcase
         for (int i = 0; i < N_TIMERS; i++) begin
            if (ch_hit[i]) begin
               case (tsel)
                  R_TH:    rdata = 32'(tmr_q[i].th);
                  R_TL:    rdata = 32'(tmr_q[i].tl);
                  R_TCON:  rdata = {29'b0, tmr_q[i].one_shot, tmr_q[i].irq_en, tmr_q[i].en};
                  R_PRESC: rdata = 32'(tmr_q[i].presc);
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous, so it is sampled here at the edge and kept out of the sensitivity list.
      if (!reset) begin
         led_q      <= '0;
         digi_q     <= '0;
         irq_stat_q <= '0;
         irq_mask_q <= '0;
         irqout_q   <= 1'b0;
         // NOTE: the channel array is plain flops rather than a RAM, so it takes the reset like any other register.
         for (int i = 0; i < N_TIMERS; i++) begin
            tmr_q[i] <= '0;
         end
      end else begin
         led_q      <= led_d;
         digi_q     <= digi_d;
         irq_stat_q <= irq_stat_d;
         irq_mask_q <= irq_mask_d;
         irqout_q   <= irqout_d;
         for (int i = 0; i < N_TIMERS; i++) begin
            tmr_q[i] <= tmr_d[i];
         end
      end
   end

   assign led    = led_q;
   assign digi   = digi_q;
   assign irqout = irqout_q;

endmodule
